// File: rtl/taillight_pwm_dimmer_if.sv
// Lamp command/drive bundle between the turn/hazard sequencer side and the dimmer.
interface taillight_pwm_dimmer_if #(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned PWM_BITS = 4
);
  logic                lights;
  logic                ramp_en;
  logic [PWM_BITS-1:0] dim_level;
  logic [LAMPS-1:0]    cmd_l;
  logic [LAMPS-1:0]    cmd_r;
  logic [LAMPS-1:0]    lamp_l;
  logic [LAMPS-1:0]    lamp_r;
  logic                settled;

  // Sequencer/testbench side: issues commands, observes lamp drive.
  modport master (
    output lights, ramp_en, dim_level, cmd_l, cmd_r,
    input  lamp_l, lamp_r, settled
  );

  // Dimmer side: consumes commands, produces lamp drive.
  modport slave (
    input  lights, ramp_en, dim_level, cmd_l, cmd_r,
    output lamp_l, lamp_r, settled
  );
endinterface

// File: rtl/taillight_pwm_dimmer.sv
// PWM tail-light dimmer: per-lamp brightness level with optional fade ramp,
// unlit lamps glow at dim_level while headlights are on.
module taillight_pwm_dimmer #(
  parameter int unsigned LAMPS        = 3,
  parameter int unsigned PWM_BITS     = 4,
  parameter int unsigned RAMP_PERIODS = 2
) (
  input  logic                   dimclk,
  input  logic                   reset,
  taillight_pwm_dimmer_if.slave  bus
);

  localparam int unsigned NLAMP = 2 * LAMPS;
  localparam int unsigned PRE_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] MAX      = '1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(RAMP_PERIODS - 1);

  logic [PWM_BITS-1:0]                  cnt_q, cnt_d;
  logic [PRE_W-1:0]                     pre_q, pre_d;
  logic [NLAMP-1:0][PWM_BITS-1:0]       lvl_q, lvl_d;
  logic [NLAMP-1:0]                     lamp_q, lamp_d;
  logic                                 settled_q, settled_d;
  logic [NLAMP-1:0][PWM_BITS-1:0]       tgt_c;
  logic [NLAMP-1:0]                     cmd_all_c;
  logic                                 wrap_c;
  logic                                 step_c;

  // Left bank occupies the low indices, right bank the high ones.
  assign cmd_all_c = {bus.cmd_r, bus.cmd_l};

  // Free-running PWM counter and wrap prescaler; a step fires on the last wrap of a ramp period.
  always_comb begin
    wrap_c = (cnt_q == MAX);
    step_c = wrap_c && (pre_q == PRE_LAST);
    cnt_d  = cnt_q + 1'b1;
    pre_d  = pre_q;
    if (step_c) begin
      pre_d = '0;
    end else if (wrap_c) begin
      pre_d = pre_q + 1'b1;
    end
  end

  // Per-lamp target: commanded lamps full on, others glow only with headlights.
  always_comb begin
    tgt_c = '0;
    for (int unsigned i = 0; i < NLAMP; i++) begin
      if (cmd_all_c[i]) begin
        tgt_c[i] = MAX;
      end else if (bus.lights) begin
        tgt_c[i] = bus.dim_level;
      end
    end
  end

  // Level update (jump or single step), PWM compare and settle detection.
  always_comb begin
    lvl_d     = lvl_q;
    lamp_d    = '0;
    settled_d = 1'b1;
    for (int unsigned i = 0; i < NLAMP; i++) begin
      if (!bus.ramp_en) begin
        lvl_d[i] = tgt_c[i];
      end else if (step_c) begin
        if (lvl_q[i] < tgt_c[i]) begin
          lvl_d[i] = lvl_q[i] + 1'b1;
        end else if (lvl_q[i] > tgt_c[i]) begin
          lvl_d[i] = lvl_q[i] - 1'b1;
        end
      end
      lamp_d[i] = (lvl_q[i] == MAX) || (cnt_q < lvl_q[i]);
      settled_d = settled_d & (lvl_q[i] == tgt_c[i]);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge dimclk) begin
    if (reset) begin
      cnt_q     <= '0;
      pre_q     <= '0;
      lvl_q     <= '0;
      lamp_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      lvl_q     <= lvl_d;
      lamp_q    <= lamp_d;
      settled_q <= settled_d;
    end
  end

  assign bus.lamp_l  = lamp_q[LAMPS-1:0];
  assign bus.lamp_r  = lamp_q[NLAMP-1:LAMPS];
  assign bus.settled = settled_q;

endmodule

// File: tb/tb_taillight_pwm_dimmer.sv
// Scoreboard bench for taillight_pwm_dimmer: stimulus queues per-edge expectations,
// a monitor pops and compares them after every rising edge.
module tb_taillight_pwm_dimmer;

  typedef struct {
    int       when;
    logic [2:0] l;
    logic [2:0] r;
    logic     s;
    bit       chk_lamp;
    bit       chk_s;
    int       tag;
  } exp_t;

  exp_t sb_q[$];

  logic clk = 1'b0;
  logic reset;
  int   n_edge  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rel;
  int   t0;

  taillight_pwm_dimmer_if #(.LAMPS(3), .PWM_BITS(4)) bus ();

  taillight_pwm_dimmer #(.LAMPS(3), .PWM_BITS(4), .RAMP_PERIODS(2)) dut (
    .dimclk (clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic string tag_name(input int t);
    case (t)
      0: return "reset";
      1: return "idle";
      2: return "on_latency";
      3: return "immediate_on";
      4: return "dim4";
      5: return "dim15";
      6: return "dim0";
      7: return "fade_in";
      8: return "reversal";
      9: return "reset_mid";
      10: return "ramp_restart";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic lamp_bit(input int lvl, input int c);
    return (lvl == 15) || (c < lvl);
  endfunction

  task automatic push(input int when, input logic [2:0] l, input logic [2:0] r,
                      input logic s, input bit cl, input bit cs, input int tag);
    exp_t e;
    e.when = when; e.l = l; e.r = r; e.s = s;
    e.chk_lamp = cl; e.chk_s = cs; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (n_edge < n) @(negedge clk);
  endtask

  // Assert reset at the current negedge for the given number of edges.
  task automatic do_reset(input int cycles);
    int base;
    base = n_edge;
    reset = 1'b1;
    for (int e = base + 1; e <= base + cycles; e++) push(e, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 0);
    wait_until(base + cycles);
  endtask

  // Single-lamp fade from level 0 to 15 on cmd_r[0], released at edge r.
  task automatic push_fade(input int r, input int from, input int to, input int tag);
    int d, lvl;
    for (int e = from; e <= to; e++) begin
      d   = e - 1 - r;
      lvl = (d / 32 > 15) ? 15 : d / 32;
      push(e, 3'b000, {2'b00, lamp_bit(lvl, d % 16)}, (lvl == 15), 1'b1, 1'b1, tag);
    end
  endtask

  // Monitor: compare every expectation scheduled for this edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_edge++;
      while (sb_q.size() > 0 && sb_q[0].when <= n_edge) begin
        e = sb_q.pop_front();
        if (e.when < n_edge) begin
          n_checks++; n_fail++;
          $display("FAIL %s: slot at edge %0d missed (now %0d)", tag_name(e.tag), e.when, n_edge);
        end else begin
          if (e.chk_lamp) begin
            n_checks++;
            if (bus.lamp_l !== e.l) begin
              n_fail++;
              $display("FAIL %s edge %0d: lamp_l got %b want %b", tag_name(e.tag), n_edge, bus.lamp_l, e.l);
            end
            n_checks++;
            if (bus.lamp_r !== e.r) begin
              n_fail++;
              $display("FAIL %s edge %0d: lamp_r got %b want %b", tag_name(e.tag), n_edge, bus.lamp_r, e.r);
            end
          end
          if (e.chk_s) begin
            n_checks++;
            if (bus.settled !== e.s) begin
              n_fail++;
              $display("FAIL %s edge %0d: settled got %b want %b", tag_name(e.tag), n_edge, bus.settled, e.s);
            end
          end
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int d, k, oth, r0, tgt0;
    logic ob, rb, lb;
    reset         = 1'b1;
    bus.lights    = 1'b1;
    bus.ramp_en   = 1'b0;
    bus.dim_level = 4'd0;
    bus.cmd_l     = 3'b111;
    bus.cmd_r     = 3'b000;
    @(negedge clk);

    // Reset held 3 edges with commands active.
    do_reset(3);
    reset = 1'b0; rel = n_edge;
    bus.cmd_l = 3'b000; bus.lights = 1'b0;
    for (int e = rel + 1; e <= rel + 5; e++) push(e, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 1);
    wait_until(rel + 5);

    // Immediate on: two-edge latency, then continuously lit.
    t0 = n_edge;
    bus.cmd_l = 3'b111;
    push(t0 + 1, 3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 2);
    for (int e = t0 + 2; e <= t0 + 21; e++) push(e, 3'b111, 3'b000, 1'b1, 1'b1, 1'b1, 3);
    wait_until(t0 + 22);

    // Dim glow at 4/16: lit while the counter (started at 0 after release) is 0..3.
    t0 = n_edge;
    bus.cmd_l = 3'b000; bus.lights = 1'b1; bus.dim_level = 4'd4;
    for (int e = t0 + 2; e <= t0 + 33; e++) begin
      lb = (((e - 1 - rel) % 16) < 4);
      push(e, {3{lb}}, {3{lb}}, 1'b1, 1'b1, 1'b1, 4);
    end
    wait_until(t0 + 34);

    // Glow at MAX: constantly on.
    t0 = n_edge;
    bus.dim_level = 4'd15;
    for (int e = t0 + 2; e <= t0 + 20; e++) push(e, 3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 5);
    wait_until(t0 + 21);

    // Glow at 0 behaves as headlights off.
    t0 = n_edge;
    bus.dim_level = 4'd0;
    for (int e = t0 + 2; e <= t0 + 20; e++) push(e, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 6);
    wait_until(t0 + 21);

    // Fade-in of cmd_r[0] from a fresh reset.
    do_reset(2);
    reset = 1'b0; rel = n_edge;
    bus.ramp_en = 1'b1; bus.lights = 1'b0; bus.cmd_l = 3'b000; bus.cmd_r = 3'b001;
    push_fade(rel, rel + 1, rel + 500, 7);
    wait_until(rel + 500);

    // Reversal at level 7 down to dim 3; other lamps ramp to 3 meanwhile.
    do_reset(2);
    reset = 1'b0; rel = n_edge;
    bus.ramp_en = 1'b1; bus.lights = 1'b1; bus.dim_level = 4'd3;
    bus.cmd_l = 3'b000; bus.cmd_r = 3'b001;
    for (int e = rel + 1; e <= rel + 420; e++) begin
      d    = e - 1 - rel;
      k    = d / 32;
      oth  = (k < 3) ? k : 3;
      r0   = (k <= 7) ? k : ((14 - k < 3) ? 3 : 14 - k);
      tgt0 = (d >= 230) ? 3 : 15;
      ob   = lamp_bit(oth, d % 16);
      rb   = lamp_bit(r0, d % 16);
      push(e, {3{ob}}, {ob, ob, rb}, (oth == 3) && (r0 == tgt0), 1'b1, 1'b1, 8);
    end
    wait_until(rel + 230);
    bus.cmd_r = 3'b000;
    wait_until(rel + 420);

    // Reset while the ramping lamp sits at level 9, then ramp restarts from 0.
    do_reset(2);
    reset = 1'b0; rel = n_edge;
    bus.ramp_en = 1'b1; bus.lights = 1'b0; bus.cmd_l = 3'b000; bus.cmd_r = 3'b001;
    push_fade(rel, rel + 1, rel + 290, 7);
    wait_until(rel + 290);
    t0 = n_edge;
    reset = 1'b1;
    push(t0 + 1, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 9);
    push(t0 + 2, 3'b000, 3'b000, 1'b1, 1'b1, 1'b1, 9);
    wait_until(t0 + 2);
    reset = 1'b0; rel = n_edge;
    push_fade(rel, rel + 1, rel + 80, 10);
    wait_until(rel + 81);

    // Bounded drain of anything still queued.
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached at edge %0d, want completion", n_edge);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/taillight_pwm_dimmer.md
Name: taillight_pwm_dimmer

Overview:
- Parametrised successor to the tail-light dimmer.
- Drives LAMPS lamps per side from per-lamp on/off commands produced by the turn/hazard sequencer.
- Headlights on: unlit lamps glow at a programmable PWM duty instead of a fixed 50% toggle.
- Optional fade ramp: each lamp steps its brightness toward its target rather than switching instantly. Sits between the sequencer FSM and the lamp drivers.

Parameters:
LAMPS, 3, lamps per side
PWM_BITS, 4, brightness resolution; MAX = 2^PWM_BITS-1
RAMP_PERIODS, 2, PWM periods per one-step brightness change when ramping (>=1)

Ports:
dimclk  input  1  clock
reset  input  1  synchronous, active-high reset
lights  input  1  headlights on; enables dim glow of unlit lamps
ramp_en  input  1  1 = fade ramp, 0 = immediate brightness change
dim_level  input  PWM_BITS  glow brightness for unlit lamps while lights=1
cmd_l  input  LAMPS  left lamp commands; bit LAMPS-1 outermost
cmd_r  input  LAMPS  right lamp commands; bit 0 outermost
lamp_l  output  LAMPS  left lamp drive, bit-aligned with cmd_l
lamp_r  output  LAMPS  right lamp drive, bit-aligned with cmd_r
settled  output  1  every lamp level equals its target

Behaviour:
- One clock (dimclk); reset is synchronous and active-high. All state and outputs are registered.
- Reset values: cnt=0, prescaler=0, all levels=0, lamp_l=0, lamp_r=0, settled=1. Reset overrides all other inputs, including mid-ramp.
- PWM counter cnt (PWM_BITS wide):
  - Free-running 0..MAX, wraps to 0.
  - A "wrap" is a cycle with cnt==MAX.
- Per-lamp target:
  - cmd bit = 1: MAX.
  - cmd bit = 0 and lights = 1: dim_level.
  - Otherwise: 0.
  - Targets are combinational from the current inputs.
- Per-lamp level (PWM_BITS register) update:
  - ramp_en=0: level <= target every cycle (1-cycle latency).
  - ramp_en=1: on a step cycle, level moves by exactly 1 toward target; otherwise it holds. If level == target, no change.
  - Step cycle: a wrap cycle where prescaler == RAMP_PERIODS-1.
- Prescaler:
  - Counts wraps 0..RAMP_PERIODS-1, incrementing on each wrap and resetting to 0 on a step cycle.
  - Runs regardless of ramp_en.
- Lamp drive, registered:
  - lamp <= (level==MAX) ? 1 : (cnt < level).
  - Level 0 is never lit; level MAX is always lit; level k is lit for exactly k of every 2^PWM_BITS cycles.
  - Total command-to-output latency with ramp_en=0 is 2 cycles.
- Target change mid-ramp: the next step moves toward the new target, with no restart of the prescaler or cnt. Toggling ramp_en mid-ramp takes effect on the next cycle.
- dim_level = MAX with lights = 1 makes unlit lamps fully on. dim_level = 0 with lights = 1 is equivalent to lights = 0.
- settled <= AND over all 2*LAMPS lamps of (level == target), registered.
- Left and right banks are identical and independent apart from the shared cnt and prescaler.

Test Plan:
- Reset:
  - Stimulus: reset high 3 cycles with cmd_l=3'b111, lights=1.
  - Required: lamp_l=lamp_r=0 and settled=1 throughout reset. After release, cnt starts at 0 the first cycle.
- Immediate on:
  - Stimulus: ramp_en=0, lights=0, cmd_l 000->111 at cycle T.
  - Required: lamp_l=111 from cycle T+2 and stays 111 continuously. lamp_r stays 000.
- Dim glow:
  - Stimulus: ramp_en=0, lights=1, dim_level=4, cmd=0.
  - Required: every lamp high exactly 4 of each 16 cycles, when the registered cnt was 0..3. With dim_level=15, lamps constant 1.
- Fade-in:
  - Stimulus: ramp_en=1, RAMP_PERIODS=2, cmd_r[0] 0->1 from level 0.
  - Required: level rises by 1 every 32 cycles and reaches 15 within 15 step cycles (<=480+32 cycles). settled=0 during the ramp and 1 one cycle after level 15. Duty grows monotonically.
- Reversal:
  - Stimulus: drop cmd_r[0] when its level=7, lights=1, dim_level=3.
  - Required: level steps 7->6->5->4->3 on consecutive step cycles, then holds at 3. settled rises after reaching 3.
- Reset mid-ramp:
  - Stimulus: assert reset while level=9.
  - Required: the next cycle has all levels 0, lamps 0, settled=1. After release, the ramp restarts from 0.
